// File: rtl/fixed_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined Q11.14 multiplier among NUM_REQ requesters.
// Define FIXED_MUL_SAT_EN to saturate overflowing results instead of wrapping them.
module fixed_mul_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*25-1:0]  req_a,
  input  logic [NUM_REQ*25-1:0]  req_b,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [24:0]            resp_data,
  output logic                   busy
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [IdxW-1:0]    ptr_q, ptr_d, gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               accept;

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [IdxW-1:0] cand;
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IdxW'((32'(ptr_q) + k) % NUM_REQ);
      if (gnt == '0 && req_valid[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign accept    = |gnt;
  assign req_ready = rst_n ? gnt : '0;
  assign ptr_d     = (gnt_idx == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx + IdxW'(1);

  logic signed [24:0] a_sel, b_sel;
  logic signed [49:0] a_ext, b_ext, prod_c;

  assign a_sel  = req_a[32'(gnt_idx)*25 +: 25];
  assign b_sel  = req_b[32'(gnt_idx)*25 +: 25];
  assign a_ext  = 50'(a_sel);
  assign b_ext  = 50'(b_sel);
  assign prod_c = a_ext * b_ext;

  logic                last_vld;
  logic [NUM_REQ-1:0]  last_id;
  logic signed [49:0]  last_prod;
  logic                mid_busy;

  if (PIPE_STAGES == 1) begin : g_single
    assign last_vld  = accept;
    assign last_id   = gnt;
    assign last_prod = prod_c;
    assign mid_busy  = 1'b0;
  end else begin : g_multi
    localparam int unsigned Mid = PIPE_STAGES - 1;

    logic [Mid-1:0]     vld_q;
    logic [NUM_REQ-1:0] id_q   [Mid];
    logic signed [49:0] prod_q [Mid];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        for (int unsigned s = 0; s < Mid; s++) begin
          id_q[s]   <= '0;
          prod_q[s] <= '0;
        end
      end else begin
        vld_q[0]  <= accept;
        id_q[0]   <= gnt;
        prod_q[0] <= prod_c;
        for (int unsigned s = 1; s < Mid; s++) begin
          vld_q[s]  <= vld_q[s-1];
          id_q[s]   <= id_q[s-1];
          prod_q[s] <= prod_q[s-1];
        end
      end
    end

    assign last_vld  = vld_q[Mid-1];
    assign last_id   = id_q[Mid-1];
    assign last_prod = prod_q[Mid-1];
    assign mid_busy  = |vld_q;
  end

  // Round half up: add half an LSB of the Q11.14 result, then floor.
  logic signed [49:0] rnd;
  logic [24:0]        res;

  assign rnd = (last_prod + 50'sd8192) >>> 14;

`ifdef FIXED_MUL_SAT_EN
  always_comb begin
    if (rnd > 50'sd16777215) begin
      res = 25'h0FFFFFF;
    end else if (rnd < -50'sd16777216) begin
      res = 25'h1000000;
    end else begin
      res = rnd[24:0];
    end
  end
`else
  logic unused_rnd;
  assign res        = rnd[24:0];
  assign unused_rnd = ^rnd[49:25];
`endif

  logic [NUM_REQ-1:0] resp_valid_q;
  logic [24:0]        resp_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      if (accept) begin
        ptr_q <= ptr_d;
      end
      resp_valid_q <= last_vld ? last_id : '0;
      if (last_vld) begin
        resp_data_q <= res;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign busy       = mid_busy | (|resp_valid_q);

endmodule

// File: tb/tb_fixed_mul_arbiter.sv
// Self-checking bench for fixed_mul_arbiter: directed cases plus random traffic against a
// queue-based reference model. Honours FIXED_MUL_SAT_EN when defined.
module tb_fixed_mul_arbiter;

  localparam int N = 4;
  localparam int P = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*25-1:0]  req_a;
  logic [N*25-1:0]  req_b;
  logic [N-1:0]     resp_valid;
  logic [24:0]      resp_data;
  logic             busy;
  logic [24:0]      a_op [N];
  logic [24:0]      b_op [N];

  assign req_a = {a_op[3], a_op[2], a_op[1], a_op[0]};
  assign req_b = {b_op[3], b_op[2], b_op[1], b_op[0]};

  always #5 clk = ~clk;

  fixed_mul_arbiter #(
    .NUM_REQ    (N),
    .PIPE_STAGES(P)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .busy      (busy)
  );

  typedef struct {
    int          due;
    int          id;
    logic [24:0] data;
  } exp_t;

  exp_t        q[$];
  int          m_ptr;
  int          cyc_n;
  int          last_gnt;
  logic [24:0] last_data;
  int          tests;
  int          fails;

  function automatic logic [24:0] ref_mul(logic [24:0] a, logic [24:0] b);
    longint sa, sb, r;
    sa = $signed(a);
    sb = $signed(b);
    r  = (sa * sb + 64'sd8192) >>> 14;
`ifdef FIXED_MUL_SAT_EN
    if (r > 64'sd16777215) r = 64'sd16777215;
    else if (r < -64'sd16777216) r = -64'sd16777216;
`endif
    return r[24:0];
  endfunction

  function automatic int model_grant(logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [24:0] itof(int x);
    int s;
    s = x * 16384;
    return s[24:0];
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  // One clock: compare all outputs at the falling edge, advance the model at the rising edge.
  task automatic cyc();
    int           g;
    logic [N-1:0] exp_rv;
    @(negedge clk);
    while (q.size() > 0 && q[0].due < cyc_n) void'(q.pop_front());
    exp_rv = '0;
    if (q.size() > 0 && q[0].due == cyc_n) begin
      exp_rv    = N'(1) << q[0].id;
      last_data = q[0].data;
    end
    g = rst_n ? model_grant(req_valid) : -1;
    check("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    check("resp_valid", 32'(resp_valid), 32'(exp_rv));
    check("resp_data", 32'(resp_data), 32'(last_data));
    check("busy", 32'(busy), 32'(q.size() > 0 && (q[0].due - P) < cyc_n));
    @(posedge clk);
    last_gnt = -1;
    if (rst_n && g >= 0) begin
      q.push_back('{due: cyc_n + P, id: g, data: ref_mul(a_op[g], b_op[g])});
      m_ptr    = (g + 1) % N;
      last_gnt = g;
    end
    cyc_n++;
    #1;
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0;
    q.delete();
    m_ptr     = 0;
    last_data = '0;
    repeat (n) cyc();
    rst_n = 1'b1;
  endtask

  task automatic single(string tag, int id, logic [24:0] a, logic [24:0] b, logic [24:0] exp);
    a_op[id]  = a;
    b_op[id]  = b;
    req_valid = N'(1) << id;
    cyc();
    req_valid = '0;
    repeat (P - 1) cyc();
    check({tag, "_id"}, 32'(resp_valid), 32'd1 << id);
    check({tag, "_data"}, 32'(resp_data), 32'(exp));
    repeat (2) cyc();
  endtask

  int rr2[4] = '{0, 1, 3, 0};

  initial begin
    tests     = 0;
    fails     = 0;
    cyc_n     = 0;
    m_ptr     = 0;
    last_gnt  = -1;
    last_data = '0;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      a_op[i] = '0;
      b_op[i] = '0;
    end
    do_reset(3);

    // Round-robin with everyone valid, operands distinct per requester.
    for (int i = 0; i < N; i++) begin
      a_op[i] = itof(i + 1);
      b_op[i] = itof(3);
    end
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr_all", 32'(req_ready), 32'd1 << (k % 4));
      cyc();
    end
    req_valid = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_drop2", 32'(req_ready), 32'd1 << rr2[k]);
      cyc();
    end
    req_valid = '0;
    repeat (P + 1) cyc();

    single("basic", 0, 25'd24576, 25'd32768, 25'd49152);
    single("rnd_pos_half", 0, 25'd1, 25'd8192, 25'd1);
    single("rnd_neg_half", 2, -25'sd1, 25'd8192, 25'd0);
    single("rnd_below_half", 1, 25'd1, 25'd8191, 25'd0);
`ifdef FIXED_MUL_SAT_EN
    single("ovf_pos", 3, itof(1000), itof(100), 25'h0FFFFFF);
    single("ovf_neg", 3, itof(-1000), itof(100), 25'h1000000);
`else
    single("ovf_pos", 3, itof(1000), itof(100), 25'h1A80000);
    single("ovf_neg", 3, itof(-1000), itof(100), 25'h0580000);
`endif

    // Requesters 1 and 3 alternate, one accept per cycle.
    for (int k = 0; k < 10; k++) begin
      int id;
      id        = (k % 2 == 0) ? 1 : 3;
      a_op[id]  = 25'(k * 3001 + 7);
      b_op[id]  = 25'(-(k * 517 + 11));
      req_valid = N'(1) << id;
      #1;
      check("b2b_grant", 32'(req_ready), 32'd1 << id);
      cyc();
    end
    req_valid = '0;
    repeat (P - 1) cyc();
    check("b2b_last_resp", 32'(resp_valid), 32'd1 << 3);
    check("b2b_busy_last", 32'(busy), 32'd1);
    cyc();
    check("b2b_busy_off", 32'(busy), 32'd0);
    repeat (2) cyc();

    // Random traffic; a requester holds its operands until granted.
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_gnt == i) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          a_op[i]      = 25'($urandom());
          b_op[i]      = ($urandom_range(0, 3) == 0) ? 25'($urandom())
                                                     : 25'(int'($urandom_range(0, 65535)) - 32768);
        end
      end
      cyc();
    end
    req_valid = '0;
    repeat (P + 2) cyc();

    // Reset with two operations in flight.
    a_op[1]   = itof(2);
    b_op[1]   = itof(5);
    a_op[2]   = itof(7);
    b_op[2]   = itof(-3);
    req_valid = 4'b0110;
    cyc();
    cyc();
    do_reset(3);
    req_valid = '1;
    #1;
    check("post_reset_grant", 32'(req_ready), 32'd1);
    cyc();
    req_valid = '0;
    repeat (P + 2) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
